// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: controller states,
// pattern modes, start patterns and the bounce direction.
package led_pkg;

    // Controller state, exported on oSTATE with this exact encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Pattern selection as presented on iMODE.
    localparam logic [1:0] MODE_SHL    = 2'd0;
    localparam logic [1:0] MODE_SHR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Pattern shown on the START edge for each mode.
    localparam logic [7:0] INIT_SHL    = 8'h01;
    localparam logic [7:0] INIT_SHR    = 8'h80;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_BLINK  = 8'hFF;

    // Travel direction of the lit LED in bounce mode.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Pattern plus direction, as produced by one step.
    typedef struct packed {
        dir_t       dir;
        logic [7:0] led;
    } pattern_t;

    // Start pattern for a freshly latched mode.
    function automatic logic [7:0] init_pattern(input logic [1:0] mode);
        logic [7:0] pat;
        pat = INIT_SHL;
        case (mode)
            MODE_SHL:    pat = INIT_SHL;
            MODE_SHR:    pat = INIT_SHR;
            MODE_BOUNCE: pat = INIT_BOUNCE;
            MODE_BLINK:  pat = INIT_BLINK;
            default:     pat = INIT_SHL;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Free-running divider that emits a one-cycle enable every TICK_DIV
// enabled clocks. Usable for any board timer that needs a strobe
// rather than a derived clock.
module tick_prescaler #(
    parameter int TICK_DIV = 524288,
    parameter int CNT_W    = 19
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iEN,    // count this cycle; the count holds while low
    input  logic iCLR,   // synchronous clear, wins over iEN
    output logic oTICK   // high in the last cycle of each period
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Period counter: wraps at LAST, holds when disabled so the phase survives a pause.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (iCLR) begin
            cnt <= '0;
        end else if (iEN) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The strobe is combinational so the consumer registers its effect on the wrapping edge.
    assign oTICK = iEN && !iCLR && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Running-light sequencer for the 8-LED bank. A run/pause/idle controller
// takes the synchronised button commands and advances the selected
// pattern on each prescaler tick (RUN) or on a single-step press (PAUSE).
//
// Commands: iSTART/iSTOP/iSTEP are one-cycle pulses and iHOLD is a level;
// every command is sampled on the rising edge of iCLK and takes effect on
// that same edge. Priority is iSTOP > iSTART > iSTEP/tick.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV = 524288,
    parameter int CNT_W    = 19
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [1:0] iMODE,
    input  logic       iSTART,
    input  logic       iSTOP,
    input  logic       iHOLD,
    input  logic       iSTEP,
    output logic [7:0] oLED,
    output logic       oTICK,
    output logic [1:0] oSTATE
);

    state_t     state_q, state_d;
    logic [7:0] led_q,   led_d;
    dir_t       dir_q,   dir_d;
    logic [1:0] mode_q,  mode_d;
    logic       tick_q,  tick_d;

    logic       pre_en;
    logic       pre_clr;
    logic       pre_tick;
    logic       do_step;
    pattern_t   nxt;

    // One pattern step for the latched mode. Bounce reverses at the
    // endpoints by moving straight to the neighbour, so each endpoint is
    // lit once per sweep and the pattern never goes dark.
    function automatic pattern_t step_pattern(input logic [1:0] mode,
                                              input logic [7:0] led,
                                              input dir_t       dir);
        pattern_t r;
        r.dir = dir;
        r.led = led;
        case (mode)
            MODE_SHL: r.led = {led[6:0], led[7]};
            MODE_SHR: r.led = {led[0], led[7:1]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (led[7]) begin
                        r.led = 8'h40;
                        r.dir = DIR_RIGHT;
                    end else begin
                        r.led = {led[6:0], 1'b0};
                    end
                end else begin
                    if (led[0]) begin
                        r.led = 8'h02;
                        r.dir = DIR_LEFT;
                    end else begin
                        r.led = {1'b0, led[7:1]};
                    end
                end
            end
            MODE_BLINK: r.led = ~led;
            default:    r.led = led;
        endcase
        return r;
    endfunction

    // The prescaler runs only in RUN, is held at zero in IDLE (so every
    // START begins a fresh period) and freezes in PAUSE to keep its phase.
    assign pre_en  = (state_q == RUN);
    assign pre_clr = (state_q == IDLE) || iSTOP;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (pre_en),
        .iCLR   (pre_clr),
        .oTICK  (pre_tick)
    );

    assign nxt = step_pattern(mode_q, led_q, dir_q);

    // Controller next-state and pattern update; defaults hold everything.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        do_step = 1'b0;

        case (state_q)
            IDLE: begin
                led_d = 8'h00;
                if (iSTART) begin
                    state_d = RUN;
                    mode_d  = iMODE;
                    led_d   = init_pattern(iMODE);
                    dir_d   = DIR_LEFT;
                end
            end
            RUN: begin
                if (iSTOP) begin
                    state_d = IDLE;
                    led_d   = 8'h00;
                    dir_d   = DIR_LEFT;
                end else begin
                    // A tick landing with iHOLD is applied before pausing.
                    do_step = pre_tick;
                    if (iHOLD) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (iSTOP) begin
                    state_d = IDLE;
                    led_d   = 8'h00;
                    dir_d   = DIR_LEFT;
                end else if (!iHOLD) begin
                    // Releasing hold resumes; a step press here is dropped.
                    state_d = RUN;
                end else begin
                    do_step = iSTEP;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = 8'h00;
                dir_d   = DIR_LEFT;
            end
        endcase

        if (do_step) begin
            led_d  = nxt.led;
            dir_d  = nxt.dir;
            tick_d = 1'b1;
        end
    end

    // Controller and pattern registers; oTICK is registered alongside oLED.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            led_q   <= 8'h00;
            dir_q   <= DIR_LEFT;
            mode_q  <= MODE_SHL;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign oLED   = led_q;
    assign oTICK  = tick_q;
    assign oSTATE = state_q;

endmodule
